// File: rtl/rv_pkg.sv
// Shared RV32I decode types: opcodes, ALU operations, immediate formats and
// the control bundle carried from decode into the ID/EX register.
package rv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_t;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_t;

  typedef struct packed {
    logic [31:0] imm;
    logic [4:0]  rd;
    logic        rd_we;
    alu_op_t     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic [2:0]  funct3;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        illegal;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    ctrl_t       ctrl;
  } idex_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] instr, input imm_type_t t);
    logic [31:0] imm;
    case (t)
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
    return imm;
  endfunction

  // alt selects the funct7[5] variant (SUB / SRA) where one exists
  function automatic alu_op_t alu_from_funct3(input logic [2:0] f3, input logic alt);
    alu_op_t op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_decoder.sv
// Combinational RV32I decoder: register addresses, read enables, immediate
// and the execute-stage control bundle, with illegal-instruction detection.
module rv_decoder
  import rv_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic        r1_en,
  output logic        r2_en,
  output ctrl_t       ctrl
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic       legal;
  logic       writes;
  logic       imm_en;
  imm_type_t  imm_type;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];
  assign rs1_addr = instr[19:15];
  assign rs2_addr = instr[24:20];

  always_comb begin
    ctrl        = '0;
    ctrl.rd     = instr[11:7];
    ctrl.funct3 = funct3;
    ctrl.alu_op = ALU_ADD;
    r1_en       = 1'b0;
    r2_en       = 1'b0;
    legal       = 1'b1;
    writes      = 1'b0;
    imm_en      = 1'b0;
    imm_type    = IMM_I;

    case (opcode)
      OPC_LUI: begin
        imm_type = IMM_U; imm_en = 1'b1; writes = 1'b1;
        ctrl.alu_op = ALU_PASSB; ctrl.alu_src_imm = 1'b1;
      end
      OPC_AUIPC: begin
        imm_type = IMM_U; imm_en = 1'b1; writes = 1'b1;
        ctrl.alu_src_imm = 1'b1; ctrl.alu_src_pc = 1'b1;
      end
      OPC_JAL: begin
        imm_type = IMM_J; imm_en = 1'b1; writes = 1'b1;
        ctrl.is_jal = 1'b1; ctrl.alu_src_pc = 1'b1;
      end
      OPC_JALR: begin
        imm_type = IMM_I; imm_en = 1'b1; writes = 1'b1; r1_en = 1'b1;
        ctrl.is_jalr = 1'b1; ctrl.alu_src_pc = 1'b1;
      end
      OPC_BRANCH: begin
        imm_type = IMM_B; imm_en = 1'b1; r1_en = 1'b1; r2_en = 1'b1;
        ctrl.is_branch = 1'b1; ctrl.alu_op = ALU_SUB;
      end
      OPC_LOAD: begin
        imm_type = IMM_I; imm_en = 1'b1; writes = 1'b1; r1_en = 1'b1;
        ctrl.is_load = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        imm_type = IMM_S; imm_en = 1'b1; r1_en = 1'b1; r2_en = 1'b1;
        ctrl.is_store = 1'b1; ctrl.alu_src_imm = 1'b1;
      end
      OPC_OP_IMM: begin
        imm_type = IMM_I; imm_en = 1'b1; writes = 1'b1; r1_en = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        // only the right shift reads imm[10] as an opcode bit
        ctrl.alu_op = alu_from_funct3(funct3, (funct3 == 3'b101) && instr[30]);
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          legal = 1'b0;
        if (funct3 == 3'b101 && funct7 != 7'b0000000 && funct7 != 7'b0100000)
          legal = 1'b0;
      end
      OPC_OP: begin
        writes = 1'b1; r1_en = 1'b1; r2_en = 1'b1;
        ctrl.alu_op = alu_from_funct3(funct3, instr[30]);
        if (!(funct7 == 7'b0000000 ||
              (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101))))
          legal = 1'b0;
      end
      OPC_FENCE: begin
      end
      OPC_SYSTEM: legal = 1'b0;
      default:    legal = 1'b0;
    endcase

    ctrl.imm   = imm_en ? gen_imm(instr, imm_type) : '0;
    ctrl.rd_we = writes && (instr[11:7] != 5'd0);

    if (!legal) begin
      r1_en            = 1'b0;
      r2_en            = 1'b0;
      ctrl.rd_we       = 1'b0;
      ctrl.alu_op      = ALU_ADD;
      ctrl.alu_src_imm = 1'b0;
      ctrl.alu_src_pc  = 1'b0;
      ctrl.is_load     = 1'b0;
      ctrl.is_store    = 1'b0;
      ctrl.is_branch   = 1'b0;
      ctrl.is_jal      = 1'b0;
      ctrl.is_jalr     = 1'b0;
      ctrl.illegal     = 1'b1;
    end
  end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: fetch handshake, register-file read request,
// load-use hazard bubble and the ID/EX pipeline register.
module id_stage
  import rv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc,
  input  logic            flush,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  output logic            rf_r1_en,
  output logic            rf_r2_en,
  input  logic [XLEN-1:0] rf_rs1,
  input  logic [XLEN-1:0] rf_rs2,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_rs1,
  output logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [4:0]      ex_rd,
  output logic            ex_rd_we,
  output logic [3:0]      ex_alu_op,
  output logic            ex_alu_src_imm,
  output logic            ex_alu_src_pc,
  output logic [2:0]      ex_funct3,
  output logic            ex_is_load,
  output logic            ex_is_store,
  output logic            ex_is_branch,
  output logic            ex_is_jal,
  output logic            ex_is_jalr,
  output logic            ex_illegal
);

  logic  dec_r1_en;
  logic  dec_r2_en;
  ctrl_t dec_ctrl;

  idex_t ex_q, ex_d;
  logic  ex_valid_q, ex_valid_d;
  logic  adv;
  logic  hazard;

  rv_decoder u_dec (
    .instr    (if_instr),
    .rs1_addr (rf_rs1_addr),
    .rs2_addr (rf_rs2_addr),
    .r1_en    (dec_r1_en),
    .r2_en    (dec_r2_en),
    .ctrl     (dec_ctrl)
  );

  assign rf_r1_en = if_valid & dec_r1_en;
  assign rf_r2_en = if_valid & dec_r2_en;

  assign adv    = ex_ready | ~ex_valid_q;
  assign hazard = ex_valid_q & ex_q.ctrl.is_load & (ex_q.ctrl.rd != 5'd0) &
                  ((rf_r1_en & (rf_rs1_addr == ex_q.ctrl.rd)) |
                   (rf_r2_en & (rf_rs2_addr == ex_q.ctrl.rd)));
  assign if_ready = rst & adv & (~hazard | flush);

  // flush wins even under backpressure; a bubble leaves the payload untouched
  always_comb begin
    ex_d       = ex_q;
    ex_valid_d = ex_valid_q;
    if (flush) begin
      ex_valid_d = 1'b0;
    end else if (adv) begin
      if (hazard) begin
        ex_valid_d = 1'b0;
      end else begin
        ex_valid_d = if_valid;
        ex_d.pc    = if_pc;
        ex_d.rs1   = rf_rs1;
        ex_d.rs2   = rf_rs2;
        ex_d.ctrl  = dec_ctrl;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q       <= '0;
      ex_valid_q <= 1'b0;
    end else begin
      ex_q       <= ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_pc          = ex_q.pc;
  assign ex_rs1         = ex_q.rs1;
  assign ex_rs2         = ex_q.rs2;
  assign ex_imm         = ex_q.ctrl.imm;
  assign ex_rd          = ex_q.ctrl.rd;
  assign ex_rd_we       = ex_q.ctrl.rd_we;
  assign ex_alu_op      = ex_q.ctrl.alu_op;
  assign ex_alu_src_imm = ex_q.ctrl.alu_src_imm;
  assign ex_alu_src_pc  = ex_q.ctrl.alu_src_pc;
  assign ex_funct3      = ex_q.ctrl.funct3;
  assign ex_is_load     = ex_q.ctrl.is_load;
  assign ex_is_store    = ex_q.ctrl.is_store;
  assign ex_is_branch   = ex_q.ctrl.is_branch;
  assign ex_is_jal      = ex_q.ctrl.is_jal;
  assign ex_is_jalr     = ex_q.ctrl.is_jalr;
  assign ex_illegal     = ex_q.ctrl.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: a per-cycle reference model of the decode
// stage checked at every falling edge, plus hand-computed literal checks.
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, if_valid, if_ready, flush, ex_ready;
  logic [31:0] if_instr, if_pc, rf_rs1, rf_rs2;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr, ex_rd;
  logic        rf_r1_en, rf_r2_en, ex_valid, ex_rd_we, ex_alu_src_imm, ex_alu_src_pc;
  logic [31:0] ex_pc, ex_rs1, ex_rs2, ex_imm;
  logic [3:0]  ex_alu_op;
  logic [2:0]  ex_funct3;
  logic        ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rf_val(input logic [4:0] a);
    return 32'hC0DE_0000 + {27'd0, a} * 32'h0001_0101;
  endfunction

  assign rf_rs1 = rf_val(rf_rs1_addr);
  assign rf_rs2 = rf_val(rf_rs2_addr);

  id_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .flush(flush),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_r1_en(rf_r1_en), .rf_r2_en(rf_r2_en), .rf_rs1(rf_rs1), .rf_rs2(rf_rs2),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we),
    .ex_alu_op(ex_alu_op), .ex_alu_src_imm(ex_alu_src_imm), .ex_alu_src_pc(ex_alu_src_pc),
    .ex_funct3(ex_funct3), .ex_is_load(ex_is_load), .ex_is_store(ex_is_store),
    .ex_is_branch(ex_is_branch), .ex_is_jal(ex_is_jal), .ex_is_jalr(ex_is_jalr),
    .ex_illegal(ex_illegal)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit r1, r2, we, ld, st, br, jal, jalr, ill, si, sp;
    bit imm_c, alu_c, si_c, sp_c;
    logic [31:0] imm;
    logic [3:0]  alu;
  } e_t;

  function automatic logic [3:0] alu_of(input logic [2:0] f3, input bit alt);
    logic [3:0] tab [8];
    tab = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    return tab[f3] + ((alt && (f3 == 3'd0 || f3 == 3'd5)) ? 4'd1 : 4'd0);
  endfunction

  function automatic e_t mdec(input logic [31:0] i);
    e_t e;
    logic [31:0] im_i, im_s, im_b, im_u, im_j;
    logic [6:0] f7;
    logic [2:0] f3;
    bit writes;
    e = '{default: 0};
    e.imm = '0; e.alu = '0;
    f7 = i[31:25]; f3 = i[14:12]; writes = 0;
    im_i = {{20{i[31]}}, i[31:20]};
    im_s = {{20{i[31]}}, i[31:25], i[11:7]};
    im_b = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
    im_u = {i[31:12], 12'h000};
    im_j = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
    case (i[6:0])
      7'b0110111: begin e.imm = im_u; e.imm_c = 1; e.alu = 4'd10; e.alu_c = 1;
                        e.si = 1; e.si_c = 1; writes = 1; end
      7'b0010111: begin e.imm = im_u; e.imm_c = 1; e.alu = 4'd0; e.alu_c = 1;
                        e.si = 1; e.si_c = 1; e.sp = 1; e.sp_c = 1; writes = 1; end
      7'b1101111: begin e.imm = im_j; e.imm_c = 1; e.jal = 1; e.sp = 1; e.sp_c = 1; writes = 1; end
      7'b1100111: begin e.r1 = 1; e.imm = im_i; e.imm_c = 1; e.jalr = 1;
                        e.sp = 1; e.sp_c = 1; writes = 1; end
      7'b1100011: begin e.r1 = 1; e.r2 = 1; e.imm = im_b; e.imm_c = 1; e.br = 1; end
      7'b0000011: begin e.r1 = 1; e.imm = im_i; e.imm_c = 1; e.ld = 1; writes = 1; end
      7'b0100011: begin e.r1 = 1; e.r2 = 1; e.imm = im_s; e.imm_c = 1; e.st = 1; end
      7'b0010011: begin
        e.r1 = 1; e.imm = im_i; e.imm_c = 1; e.si = 1; e.si_c = 1; writes = 1;
        e.alu = alu_of(f3, f3 == 3'd5 && f7 == 7'h20); e.alu_c = 1;
        e.ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
      end
      7'b0110011: begin
        e.r1 = 1; e.r2 = 1; writes = 1; e.si_c = 1; e.sp_c = 1;
        e.alu = alu_of(f3, f7 == 7'h20); e.alu_c = 1;
        e.ill = !(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)));
      end
      7'b0001111: ;
      default: e.ill = 1;
    endcase
    if (e.ill) begin
      e.r1 = 0; e.r2 = 0; e.ld = 0; e.st = 0; e.br = 0; e.jal = 0; e.jalr = 0; writes = 0;
      e.imm_c = 0; e.alu_c = 0; e.si_c = 0; e.sp_c = 0;
    end
    e.we = writes && (i[11:7] != 5'd0);
    return e;
  endfunction

  bit          armed = 0;
  bit          m_valid = 0;
  bit          m_zero = 0;
  e_t          m_e;
  logic [31:0] m_pc, m_instr, m_rs1, m_rs2;

  function automatic bit m_hazard();
    e_t e;
    e = mdec(if_instr);
    return m_valid && m_e.ld && m_instr[11:7] != 5'd0 && if_valid &&
           ((e.r1 && if_instr[19:15] == m_instr[11:7]) || (e.r2 && if_instr[24:20] == m_instr[11:7]));
  endfunction

  always @(posedge clk) begin : model
    bit hz, adv;
    hz  = m_hazard();
    adv = ex_ready || !m_valid;
    armed = 1;
    if (!rst) begin
      m_valid = 0; m_zero = 1;
    end else if (flush) begin
      m_valid = 0;
    end else if (adv) begin
      if (hz) m_valid = 0;
      else begin
        m_valid = if_valid; m_e = mdec(if_instr); m_instr = if_instr; m_pc = if_pc;
        m_rs1 = rf_val(if_instr[19:15]); m_rs2 = rf_val(if_instr[24:20]); m_zero = 0;
      end
    end
  end

  always @(negedge clk) begin : compare
    e_t e;
    bit adv;
    if (armed) begin
      e   = mdec(if_instr);
      adv = ex_ready || !m_valid;
      chkb("if_ready", if_ready, rst && adv && (!m_hazard() || flush));
      chk("rs1_addr", {27'd0, rf_rs1_addr}, {27'd0, if_instr[19:15]});
      chk("rs2_addr", {27'd0, rf_rs2_addr}, {27'd0, if_instr[24:20]});
      if (!if_valid || !e.ill) begin
        chkb("r1_en", rf_r1_en, if_valid && e.r1);
        chkb("r2_en", rf_r2_en, if_valid && e.r2);
      end
      chkb("ex_valid", ex_valid, m_valid);
      if (m_zero) begin
        chk("zero_pc", ex_pc, 0); chk("zero_rs1", ex_rs1, 0); chk("zero_rs2", ex_rs2, 0);
        chk("zero_imm", ex_imm, 0);
        chk("zero_ctrl", {11'd0, ex_rd, ex_rd_we, ex_alu_op, ex_alu_src_imm, ex_alu_src_pc,
                          ex_funct3, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal,
                          ex_is_jalr, ex_illegal}, 0);
      end else if (m_valid) begin
        chk("ex_pc", ex_pc, m_pc);
        chk("ex_rs1", ex_rs1, m_rs1);
        chk("ex_rs2", ex_rs2, m_rs2);
        chk("ex_rd", {27'd0, ex_rd}, {27'd0, m_instr[11:7]});
        chk("ex_funct3", {29'd0, ex_funct3}, {29'd0, m_instr[14:12]});
        chkb("ex_rd_we", ex_rd_we, m_e.we);
        chk("ex_flags", {26'd0, ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal},
            {26'd0, m_e.ld, m_e.st, m_e.br, m_e.jal, m_e.jalr, m_e.ill});
        if (m_e.imm_c) chk("ex_imm", ex_imm, m_e.imm);
        if (m_e.alu_c) chk("ex_alu_op", {28'd0, ex_alu_op}, {28'd0, m_e.alu});
        if (m_e.si_c)  chkb("ex_src_imm", ex_alu_src_imm, m_e.si);
        if (m_e.sp_c)  chkb("ex_src_pc", ex_alu_src_pc, m_e.sp);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_valid = 0; if_instr = '0; if_pc = '0;
    tick();
  endtask

  // present an instruction until fetch sees it accepted; returns stall cycles
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, output int stalls);
    bit done;
    if_valid = 1; if_instr = instr; if_pc = pc;
    stalls = 0; done = 0;
    for (int k = 0; k < 20 && !done; k++) begin
      #1;
      if (if_ready) done = 1;
      else stalls++;
      tick();
    end
    if (!done) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: instr %08h never accepted", instr);
    end
    if_valid = 0; if_instr = '0;
  endtask

  initial begin : stim
    int st;
    rst = 0; if_valid = 0; if_instr = '0; if_pc = '0; flush = 0; ex_ready = 1;
    tick();
    chkb("rst_if_ready", if_ready, 1'b0);
    tick();
    chkb("rst_ex_valid", ex_valid, 1'b0);
    rst = 1;
    idle();

    // ADDI x1,x0,5
    if_valid = 1; if_instr = 32'h0050_0093; if_pc = 32'h100;
    #1;
    chkb("addi_r1_en", rf_r1_en, 1'b1);
    chk("addi_rs1_addr", {27'd0, rf_rs1_addr}, 32'd0);
    chkb("addi_r2_en", rf_r2_en, 1'b0);
    send(32'h0050_0093, 32'h100, st);
    chkb("addi_valid", ex_valid, 1'b1);
    chk("addi_imm", ex_imm, 32'd5);
    chk("addi_rd", {27'd0, ex_rd}, 32'd1);
    chkb("addi_we", ex_rd_we, 1'b1);
    chk("addi_alu", {28'd0, ex_alu_op}, 32'd0);
    chkb("addi_src_imm", ex_alu_src_imm, 1'b1);

    // load-use through rs1: LW x5,0(x2) ; ADD x6,x5,x1
    send(32'h0001_2283, 32'h104, st);
    chk("lw_stall", st, 0);
    if_valid = 1; if_instr = 32'h0012_8333; if_pc = 32'h108;
    #1;
    chkb("lu_if_ready", if_ready, 1'b0);
    send(32'h0012_8333, 32'h108, st);
    chk("lu_stall", st, 1);
    chkb("lu_add_valid", ex_valid, 1'b1);
    chk("lu_add_rd", {27'd0, ex_rd}, 32'd6);
    chk("lu_add_alu", {28'd0, ex_alu_op}, 32'd0);

    // load-use through rs2 (SW x5,0(x1)); load to x0 never stalls
    send(32'h0001_2283, 32'h10C, st);
    send(32'h0050_A023, 32'h110, st);
    chk("lu_rs2_stall", st, 1);
    send(32'h0001_2003, 32'h114, st);
    send(32'h0000_0333, 32'h118, st);
    chk("lu_x0_stall", st, 0);

    // BEQ x1,x2,-8
    if_valid = 1; if_instr = 32'hFE20_8CE3; if_pc = 32'h11C;
    #1;
    chkb("beq_r1_en", rf_r1_en, 1'b1);
    chkb("beq_r2_en", rf_r2_en, 1'b1);
    send(32'hFE20_8CE3, 32'h11C, st);
    chk("beq_imm", ex_imm, 32'hFFFF_FFF8);
    chkb("beq_is_branch", ex_is_branch, 1'b1);
    chkb("beq_we", ex_rd_we, 1'b0);

    // backpressure holds the BEQ, then flush while stalled
    ex_ready = 0;
    if_valid = 1; if_instr = 32'h1234_51B7; if_pc = 32'h120;
    for (int c = 0; c < 3; c++) begin
      #1;
      chkb("bp_if_ready", if_ready, 1'b0);
      tick();
      chkb("bp_valid", ex_valid, 1'b1);
      chk("bp_imm", ex_imm, 32'hFFFF_FFF8);
      chk("bp_pc", ex_pc, 32'h11C);
    end
    flush = 1;
    #1;
    chkb("flush_bp_if_ready", if_ready, 1'b0);
    tick();
    flush = 0;
    chkb("flush_bp_valid", ex_valid, 1'b0);
    send(32'h1234_51B7, 32'h120, st);
    chk("lui_imm", ex_imm, 32'h1234_5000);
    chk("lui_alu", {28'd0, ex_alu_op}, 32'd10);
    ex_ready = 1;
    if_valid = 1; if_instr = 32'h0000_1417; if_pc = 32'h124; flush = 1;
    #1;
    chkb("flush_if_ready", if_ready, 1'b1);
    tick();
    flush = 0;
    chkb("flush_valid", ex_valid, 1'b0);

    // remaining instruction classes
    send(32'h0000_1417, 32'h200, st);
    chk("auipc_imm", ex_imm, 32'h0000_1000);
    chkb("auipc_src_pc", ex_alu_src_pc, 1'b1);
    send(32'h0100_00EF, 32'h204, st);
    chk("jal_imm", ex_imm, 32'd16);
    chkb("jal_is_jal", ex_is_jal, 1'b1);
    send(32'h0000_8067, 32'h208, st);
    chkb("jalr_we_x0", ex_rd_we, 1'b0);
    send(32'h0020_A423, 32'h20C, st);
    chk("sw_imm", ex_imm, 32'd8);
    send(32'h0000_000F, 32'h210, st);
    send(32'h4020_8233, 32'h214, st);
    chk("sub_alu", {28'd0, ex_alu_op}, 32'd1);
    send(32'h4030_D293, 32'h218, st);
    chk("srai_alu", {28'd0, ex_alu_op}, 32'd7);

    // illegal encodings
    send(32'hFFFF_FFFF, 32'h21C, st);
    chkb("ill_ones", ex_illegal, 1'b1);
    chkb("ill_ones_we", ex_rd_we, 1'b0);
    chkb("ill_ones_valid", ex_valid, 1'b1);
    send(32'h4020_A233, 32'h220, st);
    chkb("ill_subslt", ex_illegal, 1'b1);
    chkb("ill_subslt_we", ex_rd_we, 1'b0);
    send(32'h4030_9293, 32'h224, st);
    chkb("ill_slli", ex_illegal, 1'b1);
    send(32'h0000_0073, 32'h228, st);
    chkb("ill_ecall", ex_illegal, 1'b1);
    send(32'h0000_0001, 32'h22C, st);
    chkb("ill_rvc", ex_illegal, 1'b1);

    // reset while stalled with a valid ID/EX entry
    send(32'h0050_0093, 32'h300, st);
    ex_ready = 0;
    if_valid = 1; if_instr = 32'h1234_51B7; if_pc = 32'h304;
    tick();
    chkb("rst2_pre_valid", ex_valid, 1'b1);
    rst = 0;
    #1;
    chkb("rst2_if_ready", if_ready, 1'b0);
    tick();
    chkb("rst2_valid", ex_valid, 1'b0);
    chk("rst2_pc", ex_pc, 0);
    chk("rst2_imm", ex_imm, 0);
    chk("rst2_rd", {27'd0, ex_rd}, 0);
    rst = 1; ex_ready = 1;
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
Decode stage of the rv32i pipeline. It sits between fetch and the register file / execute stage.
- Accepts one fetched instruction per cycle over a valid/ready handshake.
- Decodes RV32I fields and drives the register-file read addresses and enables combinationally.
- Captures the read operands and decoded control into the ID/EX pipeline register.
- Detects load-use hazards against the instruction held in ID/EX and inserts a one-cycle bubble.

Parameters:
XLEN, 32, datapath width (only 32 supported)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-low
if_valid  in  1  fetch presents an instruction
if_ready  out  1  id_stage accepts the instruction this cycle
if_instr  in  32  instruction word
if_pc  in  32  instruction address
flush  in  1  discard the incoming instruction and the ID/EX contents (taken branch/jump from EX)
rf_rs1_addr, rf_rs2_addr  out  5 each  instr[19:15], instr[24:20]
rf_r1_en, rf_r2_en  out  1 each  read enables (decoded; 0 when !if_valid)
rf_rs1, rf_rs2  in  32 each  register-file read data (same cycle)
ex_ready  in  1  execute accepts ID/EX contents
ex_valid  out  1  ID/EX holds a valid instruction
ex_pc, ex_rs1, ex_rs2, ex_imm  out  32 each  registered payload
ex_rd  out  5  destination register
ex_rd_we  out  1  writes rd (0 if rd==0 or illegal)
ex_alu_op  out  4  rv_pkg alu op
ex_alu_src_imm  out  1  ALU B operand = imm
ex_alu_src_pc  out  1  ALU A operand = pc (AUIPC, JAL, JALR link)
ex_funct3  out  3  branch/load/store size and kind
ex_is_load, ex_is_store, ex_is_branch, ex_is_jal, ex_is_jalr, ex_illegal  out  1 each

Behaviour:
- Reset (rst==0 at a clock edge):
  - ex_valid and all ex_* registers become 0.
  - if_ready is forced to 0 while rst==0.
  - Reset mid-operation drops any in-flight ID/EX instruction.
- adv = ex_ready | !ex_valid.
- hazard = ex_valid & ex_is_load & ex_rd!=0 & ((rf_r1_en & rf_rs1_addr==ex_rd) | (rf_r2_en & rf_rs2_addr==ex_rd)).
- if_ready = rst & adv & (!hazard | flush).
- On each clock edge when adv==1, priority order:
  1. flush → ex_valid<=0; the incoming instruction is consumed and discarded.
  2. hazard → ex_valid<=0 (bubble); the instruction is not consumed and fetch holds it.
  3. otherwise ex_valid<=if_valid and the payload loads from the decode outputs.
- When adv==0, all ex_* hold their values (stable under backpressure). Flush is still honoured in this case: ex_valid<=0.
- Load-use stall costs exactly one cycle. MEM/WB forwarding is the responsibility of the execute stage.
- Opcode decode (instr[6:0]):

  | Opcode | Class | r1_en | r2_en | imm | ALU op / sources |
  |---|---|---|---|---|---|
  | 0110111 | LUI | 0 | 0 | U | PASSB, src_imm |
  | 0010111 | AUIPC | 0 | 0 | U | ADD, src_pc, src_imm |
  | 1101111 | JAL | 0 | 0 | J | is_jal |
  | 1100111 | JALR | 1 | 0 | I | is_jalr |
  | 1100011 | BRANCH | 1 | 1 | B | is_branch, rd_we=0 |
  | 0000011 | LOAD | 1 | 0 | I | is_load |
  | 0100011 | STORE | 1 | 1 | S | is_store, rd_we=0 |
  | 0010011 | OP-IMM | 1 | 0 | I | src_imm |
  | 0110011 | OP | 1 | 1 | — | — |
  | 0001111 | FENCE | 0 | 0 | — | NOP, rd_we=0 |

- Anything else is illegal, including SYSTEM and instr[1:0]!=11.
- Also illegal:
  - OP with funct7 not 0000000, or 0100000 used with anything other than ADD/SRL.
  - OP-IMM shift with imm[11:5] not 0000000, or 0100000 used with anything other than SRAI.
- An illegal instruction propagates with ex_illegal=1 and rd_we=ex_is_*=0.
- Immediates are sign-extended from instr[31]:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
- ex_rs1/ex_rs2 capture rf_rs1/rf_rs2 unmodified.

Decomposition:
- rv_pkg holds:
  - opcode constants (OPC_LUI … OPC_SYSTEM)
  - alu_op_t, 4 bits: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10
  - imm_type_t: I, S, B, U, J
- One combinational sub-module, rv_decoder (instr → fields/enables/imm/control/illegal).
- id_stage keeps the handshake, hazard detection and ID/EX register.

Test Plan:
1. ADDI x1,x0,5 (0x00500093), ex_ready=1 → rf_r1_en=1, rf_rs1_addr=0, rf_r2_en=0. Next cycle: ex_valid=1, ex_imm=5, ex_rd=1, ex_rd_we=1, alu_op=ADD, src_imm=1.
2. LW x5,0(x2) (0x00012283) then ADD x6,x5,x1 (0x00128333) → one cycle with if_ready=0 and ex_valid=0 bubble, then ADD issues with ex_rd=6, alu_op=ADD.
3. BEQ x1,x2,-8 (0xFE208CE3) → ex_imm=0xFFFFFFF8, ex_is_branch=1, ex_rd_we=0, both enables 1.
4. ex_ready=0 for 3 cycles with ex_valid=1 → all ex_* stable and if_ready=0. flush=1 with if_valid=1 → next cycle ex_valid=0, instruction consumed.
5. if_instr=0xFFFFFFFF and SUB-encoded SLT (funct7=0100000, funct3=010) → ex_illegal=1, ex_rd_we=0, ex_valid=1.
6. rst=0 for one edge while ex_valid=1 and the stage is stalled → ex_valid=0, every ex_* = 0, if_ready=0 during reset.
